// File: rtl/pe_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : pe_array_ctrl_pkg
// Brief   : Shared constants and state encoding for the pe_array tile
//           sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package pe_array_ctrl_pkg;

  // Number of PEs in the pe_array column.
  localparam int NUM_PE = 10;

  // Systolic skew across the column plus the MAC register stage.
  localparam int CTRL_DRAIN_DEFAULT = NUM_PE + 1;

  // Sequencer state encoding.
  typedef enum logic [2:0] {
    CTRL_IDLE   = 3'd0,
    CTRL_CLEAR  = 3'd1,
    CTRL_STREAM = 3'd2,
    CTRL_DRAIN  = 3'd3,
    CTRL_CAPT   = 3'd4,
    CTRL_WRITE  = 3'd5,
    CTRL_DONE   = 3'd6
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_array_ctrl_tile_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : tile_addr_gen
// Brief  : k/j counters, B-offset accumulator and the three buffer address
//          adders for the pe_array tile sequencer. Address outputs are
//          registered and hold their value when not updated.
// Rev    : 1.0  initial release
// ============================================================================
module tile_addr_gen
  import pe_array_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init,        // latch config, issue k=0 of tile 0
  input  logic              next_tile,   // advance j, issue k=0 of new tile
  input  logic              next_k,      // issue the next k of this tile
  input  logic              capture,     // present p address of tile j
  input  logic [LEN_W-1:0]  cfg_k,
  input  logic [LEN_W-1:0]  cfg_n,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_p_base,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] p_addr,
  output logic              last_k,      // index just issued was K-1
  output logic              last_j       // current tile is N-1
);

  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] p_base;
  logic [LEN_W-1:0]  len_k;
  logic [LEN_W-1:0]  len_n;
  logic [LEN_W-1:0]  k_idx;   // index of the next read to issue
  logic [LEN_W-1:0]  j_idx;   // current tile
  logic [ADDR_W-1:0] b_off;   // j*K, kept incrementally (mod 2^ADDR_W)

  logic [ADDR_W-1:0] k_ext;
  logic [ADDR_W-1:0] j_ext;
  logic [ADDR_W-1:0] b_off_next;

  assign k_ext      = ADDR_W'(k_idx);
  assign j_ext      = ADDR_W'(j_idx);
  assign b_off_next = b_off + ADDR_W'(len_k);

  assign last_k = (k_idx == len_k);
  assign last_j = (j_idx == (len_n - LEN_W'(1)));

  // Counter/accumulator update and registered address generation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_base <= '0;
      b_base <= '0;
      p_base <= '0;
      len_k  <= '0;
      len_n  <= '0;
      k_idx  <= '0;
      j_idx  <= '0;
      b_off  <= '0;
      a_addr <= '0;
      b_addr <= '0;
      p_addr <= '0;
    end else if (init) begin
      // Bases come straight from the inputs so read k=0 issues immediately.
      a_base <= cfg_a_base;
      b_base <= cfg_b_base;
      p_base <= cfg_p_base;
      len_k  <= cfg_k;
      len_n  <= cfg_n;
      k_idx  <= LEN_W'(1);
      j_idx  <= '0;
      b_off  <= '0;
      a_addr <= cfg_a_base;
      b_addr <= cfg_b_base;
    end else if (next_tile) begin
      j_idx  <= j_idx + LEN_W'(1);
      b_off  <= b_off_next;
      k_idx  <= LEN_W'(1);
      a_addr <= a_base;
      b_addr <= b_base + b_off_next;
    end else if (next_k) begin
      k_idx  <= k_idx + LEN_W'(1);
      a_addr <= a_base + k_ext;
      b_addr <= b_base + b_off + k_ext;
    end else if (capture) begin
      p_addr <= p_base + j_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pe_array_ctrl
// Brief  : Tile sequencer for the 10-PE pe_array column. Streams A/B buffer
//          reads, clears the array, waits out the systolic skew, captures the
//          psums and writes them to the output buffer, N tiles per start.
// Rev    : 1.0  initial release
// ============================================================================
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10,
  parameter int DRAIN  = CTRL_DRAIN_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  cfg_k_i,
  input  logic [LEN_W-1:0]  cfg_n_i,
  input  logic [ADDR_W-1:0] cfg_a_base_i,
  input  logic [ADDR_W-1:0] cfg_b_base_i,
  input  logic [ADDR_W-1:0] cfg_p_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              abuf_re_o,
  output logic [ADDR_W-1:0] abuf_addr_o,
  output logic              bbuf_re_o,
  output logic [ADDR_W-1:0] bbuf_addr_o,
  output logic              arr_clr_o,
  output logic              arr_we_o,
  output logic              pbuf_we_o,
  output logic [ADDR_W-1:0] pbuf_addr_o
);

  localparam int CNT_W = $clog2(DRAIN + 2);

  ctrl_state_e      state;
  logic [CNT_W-1:0] drain_cnt;

  logic degenerate;
  logic gen_init;
  logic gen_next_tile;
  logic gen_next_k;
  logic gen_capture;
  logic last_k;
  logic last_j;

  assign degenerate    = (cfg_k_i == '0) || (cfg_n_i == '0);
  assign gen_init      = (state == CTRL_IDLE) && start_i && !abort_i && !degenerate;
  assign gen_next_tile = (state == CTRL_WRITE) && !last_j && !abort_i;
  assign gen_next_k    = ((state == CTRL_CLEAR) || (state == CTRL_STREAM))
                         && !last_k && !abort_i;
  assign gen_capture   = (state == CTRL_CAPT) && !abort_i;

  tile_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .init       (gen_init),
    .next_tile  (gen_next_tile),
    .next_k     (gen_next_k),
    .capture    (gen_capture),
    .cfg_k      (cfg_k_i),
    .cfg_n      (cfg_n_i),
    .cfg_a_base (cfg_a_base_i),
    .cfg_b_base (cfg_b_base_i),
    .cfg_p_base (cfg_p_base_i),
    .a_addr     (abuf_addr_o),
    .b_addr     (bbuf_addr_o),
    .p_addr     (pbuf_addr_o),
    .last_k     (last_k),
    .last_j     (last_j)
  );

  // Sequencer FSM; every strobe is registered alongside the state it belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= CTRL_IDLE;
      drain_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      abuf_re_o <= 1'b0;
      bbuf_re_o <= 1'b0;
      arr_clr_o <= 1'b0;
      arr_we_o  <= 1'b0;
      pbuf_we_o <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      done_o    <= 1'b0;
      abuf_re_o <= 1'b0;
      bbuf_re_o <= 1'b0;
      arr_clr_o <= 1'b0;
      arr_we_o  <= 1'b0;
      pbuf_we_o <= 1'b0;
      if (abort_i) begin
        state  <= CTRL_IDLE;
        busy_o <= 1'b0;
      end else begin
        unique case (state)
          CTRL_IDLE: begin
            if (start_i) begin
              busy_o <= 1'b1;
              if (degenerate) begin
                state  <= CTRL_DONE;
                done_o <= 1'b1;
              end else begin
                state     <= CTRL_CLEAR;
                arr_clr_o <= 1'b1;
                abuf_re_o <= 1'b1;
                bbuf_re_o <= 1'b1;
              end
            end
          end
          CTRL_CLEAR, CTRL_STREAM: begin
            if (last_k) begin
              // DRAIN+1 cycles here: the extra cycle absorbs the buffer read
              // latency ahead of the column skew and MAC stage.
              state     <= CTRL_DRAIN;
              drain_cnt <= CNT_W'(DRAIN);
            end else begin
              state     <= CTRL_STREAM;
              abuf_re_o <= 1'b1;
              bbuf_re_o <= 1'b1;
            end
          end
          CTRL_DRAIN: begin
            if (drain_cnt == '0) begin
              state    <= CTRL_CAPT;
              arr_we_o <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - CNT_W'(1);
            end
          end
          CTRL_CAPT: begin
            state     <= CTRL_WRITE;
            pbuf_we_o <= 1'b1;
          end
          CTRL_WRITE: begin
            if (last_j) begin
              state  <= CTRL_DONE;
              done_o <= 1'b1;
            end else begin
              state     <= CTRL_CLEAR;
              arr_clr_o <= 1'b1;
              abuf_re_o <= 1'b1;
              bbuf_re_o <= 1'b1;
            end
          end
          CTRL_DONE: begin
            state  <= CTRL_IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= CTRL_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pe_array_ctrl
// Brief  : Directed self-checking bench for the pe_array tile sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pe_array_ctrl;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;
  localparam int DRAIN  = 11;
  localparam int AMASK  = (1 << ADDR_W) - 1;
  // Per-tile cycle count is K + TILE_EXTRA.
  localparam int TILE_EXTRA = DRAIN + 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic              abort_i;
  logic [LEN_W-1:0]  cfg_k_i;
  logic [LEN_W-1:0]  cfg_n_i;
  logic [ADDR_W-1:0] cfg_a_base_i;
  logic [ADDR_W-1:0] cfg_b_base_i;
  logic [ADDR_W-1:0] cfg_p_base_i;
  logic              busy_o;
  logic              done_o;
  logic              abuf_re_o;
  logic [ADDR_W-1:0] abuf_addr_o;
  logic              bbuf_re_o;
  logic [ADDR_W-1:0] bbuf_addr_o;
  logic              arr_clr_o;
  logic              arr_we_o;
  logic              pbuf_we_o;
  logic [ADDR_W-1:0] pbuf_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  pe_array_ctrl #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .DRAIN  (DRAIN)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .cfg_k_i      (cfg_k_i),
    .cfg_n_i      (cfg_n_i),
    .cfg_a_base_i (cfg_a_base_i),
    .cfg_b_base_i (cfg_b_base_i),
    .cfg_p_base_i (cfg_p_base_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .abuf_re_o    (abuf_re_o),
    .abuf_addr_o  (abuf_addr_o),
    .bbuf_re_o    (bbuf_re_o),
    .bbuf_addr_o  (bbuf_addr_o),
    .arr_clr_o    (arr_clr_o),
    .arr_we_o     (arr_we_o),
    .pbuf_we_o    (pbuf_we_o),
    .pbuf_addr_o  (pbuf_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {26'd0, busy_o, done_o, abuf_re_o, abuf_addr_o, bbuf_re_o, bbuf_addr_o,
            arr_clr_o, arr_we_o, pbuf_we_o, pbuf_addr_o};
  endfunction

  // Run one job from start to done, logging every strobe by busy-cycle
  // number (cycle 1 is the first busy cycle) and comparing to the spec model.
  task automatic run_job(input int k, input int n, input int a_base, input int b_base,
                         input int p_base, input bit hold_start, input string name);
    int a_addr_q[$];
    int a_cyc_q[$];
    int b_addr_q[$];
    int clr_q[$];
    int we_q[$];
    int pw_cyc_q[$];
    int pw_addr_q[$];
    int done_cyc;
    int budget;
    int tile;
    int reads;
    bit degen;
    done_cyc = -1;
    degen    = (k == 0) || (n == 0);
    tile     = k + TILE_EXTRA;
    reads    = degen ? 0 : k * n;
    budget   = degen ? 8 : n * tile + 8;

    @(negedge clk_i);
    cfg_k_i      = LEN_W'(k);
    cfg_n_i      = LEN_W'(n);
    cfg_a_base_i = ADDR_W'(a_base);
    cfg_b_base_i = ADDR_W'(b_base);
    cfg_p_base_i = ADDR_W'(p_base);
    start_i      = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_i);
      if (!hold_start) start_i = 1'b0;
      if (c == 1) check({name, " busy_rise"}, busy_o, 1);
      if (abuf_re_o) begin
        a_addr_q.push_back(int'(abuf_addr_o));
        a_cyc_q.push_back(c);
      end
      if (bbuf_re_o) b_addr_q.push_back(int'(bbuf_addr_o));
      if (arr_clr_o) clr_q.push_back(c);
      if (arr_we_o)  we_q.push_back(c);
      if (pbuf_we_o) begin
        pw_cyc_q.push_back(c);
        pw_addr_q.push_back(int'(pbuf_addr_o));
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
    end
    start_i = 1'b0;

    check({name, " done_cycle"}, done_cyc, degen ? 1 : n * tile + 1);
    @(negedge clk_i);
    check({name, " idle_after_done"}, {busy_o, done_o}, 2'b00);

    check({name, " a_reads"}, a_addr_q.size(), reads);
    check({name, " b_reads"}, b_addr_q.size(), reads);
    check({name, " clr_count"}, clr_q.size(), degen ? 0 : n);
    check({name, " we_count"}, we_q.size(), degen ? 0 : n);
    check({name, " pw_count"}, pw_cyc_q.size(), degen ? 0 : n);
    for (int i = 0; i < reads && i < a_addr_q.size(); i++) begin
      check($sformatf("%s a_addr[%0d]", name, i), a_addr_q[i], (a_base + (i % k)) & AMASK);
      check($sformatf("%s a_cyc[%0d]", name, i), a_cyc_q[i], 1 + (i / k) * tile + (i % k));
    end
    for (int i = 0; i < reads && i < b_addr_q.size(); i++)
      check($sformatf("%s b_addr[%0d]", name, i), b_addr_q[i], (b_base + i) & AMASK);
    for (int j = 0; j < clr_q.size(); j++)
      check($sformatf("%s clr_cyc[%0d]", name, j), clr_q[j], 1 + j * tile);
    for (int j = 0; j < we_q.size(); j++)
      check($sformatf("%s we_cyc[%0d]", name, j), we_q[j], 1 + j * tile + k + DRAIN + 1);
    for (int j = 0; j < pw_cyc_q.size(); j++) begin
      check($sformatf("%s pw_cyc[%0d]", name, j), pw_cyc_q[j], 1 + j * tile + k + DRAIN + 2);
      check($sformatf("%s pw_addr[%0d]", name, j), pw_addr_q[j], (p_base + j) & AMASK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    int quiet;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    cfg_k_i      = '0;
    cfg_n_i      = '0;
    cfg_a_base_i = '0;
    cfg_b_base_i = '0;
    cfg_p_base_i = '0;

    repeat (3) @(negedge clk_i);
    check("reset_outputs", all_outputs(), 64'd0);
    rst_ni = 1'b1;

    // Single tile; start_i held high throughout busy must be ignored.
    run_job(4, 1, 'h10, 'h20, 'h30, 1'b1, "single");
    run_job(3, 3, 'h10, 'h100, 'h200, 1'b0, "three");
    run_job(0, 5, 'h10, 'h20, 'h30, 1'b0, "degen_k");
    run_job(6, 0, 'h10, 'h20, 'h30, 1'b0, "degen_n");
    run_job(4, 1, 'h3FE, 'h3FC, 'h3FF, 1'b0, "wrap");

    // Abort while streaming, at the cycle read k=5 is issued.
    hits = 0;
    @(negedge clk_i);
    cfg_k_i      = 10'd8;
    cfg_n_i      = 10'd1;
    cfg_a_base_i = 10'h040;
    cfg_b_base_i = 10'h080;
    cfg_p_base_i = 10'h050;
    start_i      = 1'b1;
    for (int c = 1; c <= 12 && hits == 0; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (abuf_re_o && abuf_addr_o == 10'h045) begin
        hits    = 1;
        abort_i = 1'b1;
      end
    end
    check("abort_reached_k5", hits, 1);
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_idle_next", {busy_o, done_o, abuf_re_o, bbuf_re_o, arr_clr_o, arr_we_o, pbuf_we_o},
          7'd0);
    quiet = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      quiet += int'(arr_we_o) + int'(pbuf_we_o) + int'(done_o) + int'(busy_o);
    end
    check("abort_no_strobes", quiet, 0);
    run_job(4, 1, 'h10, 'h20, 'h30, 1'b0, "post_abort");

    // Asynchronous reset in the middle of DRAIN.
    @(negedge clk_i);
    cfg_k_i      = 10'd4;
    cfg_n_i      = 10'd1;
    cfg_a_base_i = 10'h011;
    cfg_b_base_i = 10'h022;
    cfg_p_base_i = 10'h033;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (7) @(negedge clk_i);
    check("rst_pre_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check("rst_async_clear", all_outputs(), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_stays_idle", busy_o, 0);
    run_job(3, 2, 'h05, 'h3F0, 'h07, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
